// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares the single ROM/RAM/keyboard memory bus between the CPU and the
// video fetch engine. VID has fixed priority, and a saturating wait counter
// lets a repeatedly losing CPU request win once it has lost CPU_MAX_WAIT
// contested cycles.
//
// Pipeline, at most one access per cycle:
//   cycle N   : arbitration on the eligible requests
//   cycle N+1 : memStrobe with the winner's address/write/data, winner's ack
//   cycle N+2 : winner's ReadValid for a read, with memDataRead

module mem_bus_arbiter #(
   parameter int ADDR_BITS    = 16,
   parameter int DATA_BITS    = 8,
   parameter int CPU_MAX_WAIT = 3
) (
   input  logic                 clk,
   input  logic                 reset,

   input  logic                 cpuReq,
   input  logic [ADDR_BITS-1:0] cpuAddr,
   input  logic                 cpuWrite,
   input  logic [DATA_BITS-1:0] cpuDataWrite,
   output logic                 cpuAck,
   output logic                 cpuReadValid,
   output logic [DATA_BITS-1:0] cpuReadData,

   input  logic                 vidReq,
   input  logic [ADDR_BITS-1:0] vidAddr,
   input  logic                 vidWrite,
   input  logic [DATA_BITS-1:0] vidDataWrite,
   output logic                 vidAck,
   output logic                 vidReadValid,
   output logic [DATA_BITS-1:0] vidReadData,

   output logic [ADDR_BITS-1:0] memAddr,
   output logic                 memStrobe,
   output logic                 memWrite,
   output logic [DATA_BITS-1:0] memDataWrite,
   input  logic [DATA_BITS-1:0] memDataRead
);

   // Four bits cover the whole legal CPU_MAX_WAIT range of 1..15.
   localparam int WAIT_BITS = 4;
   localparam logic [WAIT_BITS-1:0] WAIT_LIMIT = WAIT_BITS'(CPU_MAX_WAIT);

   logic [WAIT_BITS-1:0] waitCount;
   logic                 cpuEligible;
   logic                 vidEligible;
   logic                 cpuStarved;
   logic                 cpuGrant;
   logic                 vidGrant;

   // Arbitration: a requester whose ack is high this cycle is presenting a
   // stale request, so it sits out. VID wins ties unless the CPU has waited
   // long enough.
   always_comb begin
      cpuEligible = cpuReq & ~cpuAck;
      vidEligible = vidReq & ~vidAck;
      cpuStarved  = (waitCount >= WAIT_LIMIT);
      vidGrant    = vidEligible & ~(cpuEligible & cpuStarved);
      cpuGrant    = cpuEligible & ~vidGrant;
   end

   // Bus stage: register the winner onto the bus and ack it; with no winner
   // the strobe drops and the bus fields keep their previous values.
   always_ff @(posedge clk) begin
      if (reset) begin
         memStrobe    <= 1'b0;
         memWrite     <= 1'b0;
         memAddr      <= '0;
         memDataWrite <= '0;
         cpuAck       <= 1'b0;
         vidAck       <= 1'b0;
      end else begin
         memStrobe <= cpuGrant | vidGrant;
         cpuAck    <= cpuGrant;
         vidAck    <= vidGrant;
         if (cpuGrant) begin
            memAddr      <= cpuAddr;
            memWrite     <= cpuWrite;
            memDataWrite <= cpuDataWrite;
         end else if (vidGrant) begin
            memAddr      <= vidAddr;
            memWrite     <= vidWrite;
            memDataWrite <= vidDataWrite;
         end
      end
   end

   // Read-return stage: the ack of the current strobe identifies the owner of
   // the data the synchronous memories will present next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpuReadValid <= 1'b0;
         vidReadValid <= 1'b0;
      end else begin
         cpuReadValid <= cpuAck & ~memWrite;
         vidReadValid <= vidAck & ~memWrite;
      end
   end

   // Starvation guard: count contested cycles lost by the CPU, saturating at
   // the limit, and start over whenever the CPU gets the bus.
   always_ff @(posedge clk) begin
      if (reset) begin
         waitCount <= '0;
      end else if (cpuGrant) begin
         waitCount <= '0;
      end else if (cpuEligible && vidGrant && (waitCount < WAIT_LIMIT)) begin
         waitCount <= waitCount + 1'b1;
      end
   end

   // Both requesters see the decoded read data directly; only the owner's
   // valid makes it meaningful.
   always_comb begin
      cpuReadData = memDataRead;
      vidReadData = memDataRead;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter with a small synchronous memory model:
// RAM at 0xE000-0xE0FF, and ROM elsewhere returning addr[15:8] ^ addr[7:0].

module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpuReq, cpuWrite, vidReq, vidWrite;
   logic [15:0] cpuAddr, vidAddr;
   logic [7:0]  cpuDataWrite, vidDataWrite;
   logic        cpuAck, cpuReadValid, vidAck, vidReadValid;
   logic [7:0]  cpuReadData, vidReadData;
   logic [15:0] memAddr;
   logic        memStrobe, memWrite;
   logic [7:0]  memDataWrite;
   logic [7:0]  memDataRead = 8'h00;
   logic [7:0]  ramBytes [0:255];

   int vectorCount = 0;
   int missCount   = 0;

   mem_bus_arbiter #(.ADDR_BITS(16), .DATA_BITS(8), .CPU_MAX_WAIT(3)) dut (
      .clk(clk), .reset(reset),
      .cpuReq(cpuReq), .cpuAddr(cpuAddr), .cpuWrite(cpuWrite),
      .cpuDataWrite(cpuDataWrite), .cpuAck(cpuAck),
      .cpuReadValid(cpuReadValid), .cpuReadData(cpuReadData),
      .vidReq(vidReq), .vidAddr(vidAddr), .vidWrite(vidWrite),
      .vidDataWrite(vidDataWrite), .vidAck(vidAck),
      .vidReadValid(vidReadValid), .vidReadData(vidReadData),
      .memAddr(memAddr), .memStrobe(memStrobe), .memWrite(memWrite),
      .memDataWrite(memDataWrite), .memDataRead(memDataRead)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] romByte(input logic [15:0] a);
      return a[15:8] ^ a[7:0];
   endfunction

   // Synchronous SoC memory: data for a read strobe appears the next cycle.
   always @(posedge clk) begin
      if (memStrobe) begin
         if (memWrite) begin
            if (memAddr[15:8] == 8'hE0) ramBytes[memAddr[7:0]] <= memDataWrite;
         end else begin
            memDataRead <= (memAddr[15:8] == 8'hE0) ? ramBytes[memAddr[7:0]]
                                                   : romByte(memAddr);
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of requests, then step to just after the next rising edge.
   task automatic applyStimulus(input logic cReq, input logic [15:0] cAddr,
                                input logic cWr, input logic [7:0] cData,
                                input logic vReq, input logic [15:0] vAddr,
                                input logic vWr, input logic [7:0] vData);
      cpuReq = cReq; cpuAddr = cAddr; cpuWrite = cWr; cpuDataWrite = cData;
      vidReq = vReq; vidAddr = vAddr; vidWrite = vWr; vidDataWrite = vData;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(0, 16'h0, 0, 8'h0, 0, 16'h0, 0, 8'h0);
      applyStimulus(0, 16'h0, 0, 8'h0, 0, 16'h0, 0, 8'h0);
      checkOutput("rst.strobe", memStrobe, 0);
      checkOutput("rst.write", memWrite, 0);
      checkOutput("rst.addr", memAddr, 16'h0000);
      checkOutput("rst.wdata", memDataWrite, 8'h00);
      checkOutput("rst.acks", {cpuAck, vidAck}, 2'b00);
      checkOutput("rst.valids", {cpuReadValid, vidReadValid}, 2'b00);
      reset = 1'b0;

      // CPU-only read of ROM 0x0123 -> 0x01 ^ 0x23 = 0x22
      applyStimulus(1, 16'h0123, 0, 8'h0, 0, 16'h0, 0, 8'h0);
      checkOutput("rd.strobe", memStrobe, 1);
      checkOutput("rd.addr", memAddr, 16'h0123);
      checkOutput("rd.memWrite", memWrite, 0);
      checkOutput("rd.acks", {cpuAck, vidAck}, 2'b10);
      applyStimulus(0, 16'h0123, 0, 8'h0, 0, 16'h0, 0, 8'h0);
      checkOutput("rd.valid", {cpuReadValid, vidReadValid}, 2'b10);
      checkOutput("rd.data", cpuReadData, 8'h22);
      checkOutput("rd.strobeOff", memStrobe, 0);

      // Back-to-back CPU reads of 0x0010..0x0013: one access per two cycles
      for (int k = 0; k < 8; k++) begin
         applyStimulus(k < 7, 16'h0010 + 16'((k + 1) / 2), 0, 8'h0,
                       0, 16'h0, 0, 8'h0);
         checkOutput("b2b.ack", cpuAck, (k % 2) == 0);
         if ((k % 2) == 0)
            checkOutput("b2b.addr", memAddr, 16'h0010 + 16'(k / 2));
         checkOutput("b2b.valid", cpuReadValid, (k % 2) == 1);
         if ((k % 2) == 1)
            checkOutput("b2b.data", cpuReadData, 8'h10 + 8'((k - 1) / 2));
      end

      // CPU write 0x5A to RAM 0xE010, then read it back
      applyStimulus(1, 16'hE010, 1, 8'h5A, 0, 16'h0, 0, 8'h0);
      checkOutput("wr.ack", cpuAck, 1);
      checkOutput("wr.memWrite", memWrite, 1);
      checkOutput("wr.wdata", memDataWrite, 8'h5A);
      checkOutput("wr.addr", memAddr, 16'hE010);
      applyStimulus(0, 16'hE010, 1, 8'h5A, 0, 16'h0, 0, 8'h0);
      checkOutput("wr.noValid", {cpuReadValid, vidReadValid}, 2'b00);
      applyStimulus(1, 16'hE010, 0, 8'h0, 0, 16'h0, 0, 8'h0);
      checkOutput("wrRb.ack", cpuAck, 1);
      applyStimulus(0, 16'hE010, 0, 8'h0, 0, 16'h0, 0, 8'h0);
      checkOutput("wrRb.valid", cpuReadValid, 1);
      checkOutput("wrRb.data", cpuReadData, 8'h5A);

      // Contention: both held, VID wins first, then they alternate every cycle
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1, 16'h0800, 0, 8'h0,
                       1, 16'hFE00 + 16'((k + 1) / 2), 0, 8'h0);
         checkOutput("con.strobe", memStrobe, 1);
         checkOutput("con.acks", {cpuAck, vidAck}, ((k % 2) == 0) ? 2'b01 : 2'b10);
         checkOutput("con.addr", memAddr,
                     ((k % 2) == 0) ? 16'hFE00 + 16'(k / 2) : 16'h0800);
         if (k > 0) begin
            checkOutput("con.valids", {cpuReadValid, vidReadValid},
                        ((k % 2) == 1) ? 2'b01 : 2'b10);
            if ((k % 2) == 1)
               checkOutput("con.vidData", vidReadData, 8'hFE ^ 8'((k - 1) / 2));
            else
               checkOutput("con.cpuData", cpuReadData, 8'h08);
         end
      end
      applyStimulus(0, 16'h0800, 0, 8'h0, 0, 16'hFE03, 0, 8'h0);
      checkOutput("con.tailStrobe", memStrobe, 0);
      checkOutput("con.tailValids", {cpuReadValid, vidReadValid}, 2'b10);
      checkOutput("con.tailData", cpuReadData, 8'h08);

      // Starvation: CPU requests only in VID's eligible cycles and loses three
      // times; the fourth contested cycle goes to the CPU.
      applyStimulus(1, 16'h0900, 0, 8'h0, 1, 16'hFE80, 0, 8'h0);
      checkOutput("stv.c1", {cpuAck, vidAck}, 2'b01);
      applyStimulus(0, 16'h0900, 0, 8'h0, 1, 16'hFE80, 0, 8'h0);
      checkOutput("stv.gap1", {memStrobe, cpuAck, vidAck}, 3'b000);
      checkOutput("stv.vidValid", vidReadValid, 1);
      checkOutput("stv.vidData", vidReadData, 8'h7E);
      applyStimulus(1, 16'h0900, 0, 8'h0, 1, 16'hFE80, 0, 8'h0);
      checkOutput("stv.c2", {cpuAck, vidAck}, 2'b01);
      applyStimulus(0, 16'h0900, 0, 8'h0, 1, 16'hFE80, 0, 8'h0);
      checkOutput("stv.gap2", {memStrobe, cpuAck, vidAck}, 3'b000);
      applyStimulus(1, 16'h0900, 0, 8'h0, 1, 16'hFE80, 0, 8'h0);
      checkOutput("stv.c3", {cpuAck, vidAck}, 2'b01);
      applyStimulus(0, 16'h0900, 0, 8'h0, 1, 16'hFE80, 0, 8'h0);
      checkOutput("stv.gap3", {memStrobe, cpuAck, vidAck}, 3'b000);
      applyStimulus(1, 16'h0900, 0, 8'h0, 1, 16'hFE80, 0, 8'h0);
      checkOutput("stv.c4cpuWins", {cpuAck, vidAck}, 2'b10);
      checkOutput("stv.c4addr", memAddr, 16'h0900);
      applyStimulus(0, 16'h0900, 0, 8'h0, 1, 16'hFE80, 0, 8'h0);
      checkOutput("stv.vidAfter", {cpuAck, vidAck}, 2'b01);
      checkOutput("stv.cpuValid", cpuReadValid, 1);
      checkOutput("stv.cpuData", cpuReadData, 8'h09);
      applyStimulus(0, 16'h0900, 0, 8'h0, 1, 16'hFE80, 0, 8'h0);
      checkOutput("stv.gap4", {memStrobe, cpuAck, vidAck}, 3'b000);
      applyStimulus(1, 16'h0900, 0, 8'h0, 1, 16'hFE80, 0, 8'h0);
      checkOutput("stv.cleared", {cpuAck, vidAck}, 2'b01);
      applyStimulus(0, 16'h0900, 0, 8'h0, 0, 16'hFE80, 0, 8'h0);
      checkOutput("stv.drain", {memStrobe, vidReadValid}, 2'b01);
      applyStimulus(0, 16'h0900, 0, 8'h0, 0, 16'hFE80, 0, 8'h0);
      checkOutput("stv.quiet", {memStrobe, cpuAck, vidAck, cpuReadValid, vidReadValid},
                  5'b00000);

      // Reset while a VID read strobe is on the bus
      applyStimulus(0, 16'h0, 0, 8'h0, 1, 16'hFE10, 0, 8'h0);
      checkOutput("rmr.vidAck", {memStrobe, vidAck}, 2'b11);
      reset = 1'b1;
      applyStimulus(0, 16'h0, 0, 8'h0, 0, 16'h0, 0, 8'h0);
      checkOutput("rmr.cleared", {memStrobe, memWrite, cpuAck, vidAck,
                                  cpuReadValid, vidReadValid}, 6'b000000);
      checkOutput("rmr.addr", memAddr, 16'h0000);
      checkOutput("rmr.wdata", memDataWrite, 8'h00);
      reset = 1'b0;
      applyStimulus(0, 16'h0, 0, 8'h0, 0, 16'h0, 0, 8'h0);
      checkOutput("rmr.noValid", {cpuReadValid, vidReadValid}, 2'b00);
      applyStimulus(1, 16'h0123, 0, 8'h0, 0, 16'h0, 0, 8'h0);
      checkOutput("rmr.postAck", {cpuAck, memStrobe}, 2'b11);
      checkOutput("rmr.postAddr", memAddr, 16'h0123);
      applyStimulus(0, 16'h0123, 0, 8'h0, 0, 16'h0, 0, 8'h0);
      checkOutput("rmr.postValid", cpuReadValid, 1);
      checkOutput("rmr.postData", cpuReadData, 8'h22);

      // Idle: nothing moves, bus address holds its last value
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 16'h0, 0, 8'h0, 0, 16'h0, 0, 8'h0);
         checkOutput("idle.quiet", {memStrobe, cpuAck, vidAck, cpuReadValid,
                                    vidReadValid}, 5'b00000);
         checkOutput("idle.addrHold", memAddr, 16'h0123);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
